// File: rtl/cmp_pkg.sv
// cmp_pkg: shared definitions for the comparator arbiter slice.
//   state_t    : arbiter FSM states (IDLE, CMP, RESP)
//   CMP_WIDTH  : operand width of the shared magnitude comparator
//   rr_pick    : round-robin winner search, starting above the last winner
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CMP_WIDTH = 8;

    // Returns the first set bit of req found searching upward from ptr+1,
    // wrapping modulo n (n <= 8). The loop runs from the far end downward so
    // the last assignment made is the nearest requester. When req is empty
    // the result is ptr, and the caller ignores it.
    function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] ptr,
                                           input int         n);
        logic [2:0] win;
        int         idx;
        win = ptr;
        for (int k = 8; k >= 1; k--) begin
            if (k <= n) begin
                idx = (int'(ptr) + k) % n;
                if (req[idx[2:0]]) begin
                    win = idx[2:0];
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/cmp_arbiter_cmp.sv
// cmp_arbiter_cmp: the shared unsigned magnitude comparator (combinational).
//   a, b : operands
//   gt   : a > b
//   eq   : a == b
//   lt   : a < b
// Exactly one of gt/eq/lt is high for any input pair.
module cmp_arbiter_cmp
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin access to one shared comparator for N_REQ requesters.
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   req         : level request per requester
//   a_in, b_in  : packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt         : one-hot one-cycle pulse, operands of that requester captured
//   rsp_valid   : one-cycle pulse, result fields valid
//   rsp_id      : requester owning the result
//   rsp_greater/rsp_equal/rsp_less : registered unsigned compare flags
//   busy        : FSM not in IDLE
//   dbg_state   : current FSM state, for observation
//
// Handshake: req is a level; each gnt pulse consumes one request, captured at
// the edge that raises gnt. Operands need only be stable at that edge. A
// requester with no more work drops req while its gnt is high; one that holds
// req is re-queued behind the others by the round-robin pointer.
module cmp_arbiter
    import cmp_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = CMP_WIDTH,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_in,
    input  logic [N_REQ*WIDTH-1:0] b_in,
    output logic [N_REQ-1:0]       gnt,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_greater,
    output logic                   rsp_equal,
    output logic                   rsp_less,
    output logic                   busy,
    output state_t                 dbg_state
);

    state_t            state_q;
    state_t            state_d;
    logic              load;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   rr_ptr;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [ID_W-1:0]   op_id;
    logic              c_gt;
    logic              c_eq;
    logic              c_lt;

    assign winner = ID_W'(rr_pick(8'(req), 3'(rr_ptr), N_REQ));

    // Next state and capture decision. A request is only taken in IDLE or
    // RESP, which gives the 2-cycle issue rate without an idle bubble.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    load    = 1'b1;
                    state_d = CMP;
                end
            end
            CMP: begin
                state_d = RESP;
            end
            RESP: begin
                if (|req) begin
                    load    = 1'b1;
                    state_d = CMP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture of the winner's operands; the pointer moves to each winner so
    // it drops to lowest priority for the next decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            op_id  <= '0;
            rr_ptr <= ID_W'(N_REQ - 1);
        end else begin
            gnt <= '0;
            if (load) begin
                gnt    <= N_REQ'(1) << winner;
                op_a   <= a_in[int'(winner)*WIDTH +: WIDTH];
                op_b   <= b_in[int'(winner)*WIDTH +: WIDTH];
                op_id  <= winner;
                rr_ptr <= winner;
            end
        end
    end

    cmp_arbiter_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a  (op_a),
        .b  (op_b),
        .gt (c_gt),
        .eq (c_eq),
        .lt (c_lt)
    );

    // Result fields load only when leaving CMP and otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_greater <= 1'b0;
            rsp_equal   <= 1'b0;
            rsp_less    <= 1'b0;
        end else begin
            rsp_valid <= (state_q == CMP);
            if (state_q == CMP) begin
                rsp_id      <= op_id;
                rsp_greater <= c_gt;
                rsp_equal   <= c_eq;
                rsp_less    <= c_lt;
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
module tb_cmp_arbiter;
  import cmp_pkg::*;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int ID_W  = 2;

  logic                   clk;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] a_in;
  logic [N_REQ*WIDTH-1:0] b_in;
  logic [N_REQ-1:0]       gnt;
  logic                   rsp_valid;
  logic [ID_W-1:0]        rsp_id;
  logic                   rsp_greater;
  logic                   rsp_equal;
  logic                   rsp_less;
  logic                   busy;
  state_t                 dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [ID_W-1:0] exp_q[$];

  cmp_arbiter #(
    .N_REQ (N_REQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .a_in        (a_in),
    .b_in        (b_in),
    .gnt         (gnt),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_greater (rsp_greater),
    .rsp_equal   (rsp_equal),
    .rsp_less    (rsp_less),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction view: a grant may be issued at any edge that is not the edge
  // right after a grant; the result appears one cycle after the grant.
  logic [N_REQ-1:0] m_gnt;
  logic             m_valid;
  logic [ID_W-1:0]  m_id;
  logic             m_gt, m_eq, m_lt;
  int               m_ptr;
  int               m_cap_id;
  int               m_cap_a, m_cap_b;
  bit               m_was_grant;
  bit               m_found;
  int               m_idx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_gnt   = '0;
      m_valid = 1'b0;
      m_id    = '0;
      m_gt    = 1'b0;
      m_eq    = 1'b0;
      m_lt    = 1'b0;
      m_ptr   = N_REQ - 1;
    end else begin
      m_was_grant = (m_gnt != 0);
      m_valid     = m_was_grant;
      if (m_was_grant) begin
        m_id = m_cap_id[ID_W-1:0];
        m_gt = (m_cap_a > m_cap_b);
        m_eq = (m_cap_a == m_cap_b);
        m_lt = (m_cap_a < m_cap_b);
      end
      m_gnt = '0;
      if (!m_was_grant && req != 0) begin
        m_found = 0;
        for (int k = 1; k <= N_REQ; k++) begin
          m_idx = (m_ptr + k) % N_REQ;
          if (!m_found && req[m_idx]) begin
            m_found  = 1;
            m_cap_id = m_idx;
          end
        end
        m_gnt   = '0;
        m_gnt[m_cap_id] = 1'b1;
        m_cap_a = int'(a_in[m_cap_id*WIDTH +: WIDTH]);
        m_cap_b = int'(b_in[m_cap_id*WIDTH +: WIDTH]);
        m_ptr   = m_cap_id;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("gnt", gnt, m_gnt);
    check("rsp_valid", rsp_valid, m_valid);
    check("rsp_id", rsp_id, m_id);
    check("flags", {rsp_greater, rsp_equal, rsp_less}, {m_gt, m_eq, m_lt});
    check("busy", busy, (m_gnt != 0) || m_valid);
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b);
    a_in[id*WIDTH +: WIDTH] = a;
    b_in[id*WIDTH +: WIDTH] = b;
  endtask

  // One isolated operation from idle; flags given as {gt, eq, lt}.
  task automatic do_single(input string name, input int id, input logic [7:0] a,
                           input logic [7:0] b, input logic [2:0] exp_flags);
    logic [N_REQ-1:0] one;
    one = '0;
    one[id] = 1'b1;
    set_ops(id, a, b);
    req = one;
    tick();
    check({name, "_gnt"}, gnt, one);
    req = '0;
    tick();
    check({name, "_valid"}, rsp_valid, 1'b1);
    check({name, "_id"}, rsp_id, id);
    check({name, "_flags"}, {rsp_greater, rsp_equal, rsp_less}, exp_flags);
    tick();
  endtask

  logic [N_REQ-1:0] rr_gnt [5];

  initial begin
    rst  = 1'b1;
    req  = '0;
    a_in = '0;
    b_in = '0;

    // Reset state
    tick(2);
    check("rst_gnt", gnt, 4'b0000);
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, IDLE);
    #2 rst = 1'b0;
    tick(2);

    // Single request: 0x35 vs 0x12 -> greater
    do_single("single", 0, 8'h35, 8'h12, 3'b100);
    // Equal and boundary values on requester 2
    do_single("eq_ff", 2, 8'hFF, 8'hFF, 3'b010);
    do_single("lt_00ff", 2, 8'h00, 8'hFF, 3'b001);
    do_single("gt_ff00", 2, 8'hFF, 8'h00, 3'b100);

    // Fairness after a drop: grant id 1 alone, then hold 1010
    do_single("ptr1", 1, 8'h07, 8'h09, 3'b001);
    req = 4'b1010;
    tick();
    check("fair_first", gnt, 4'b1000);
    tick();
    check("fair_gap", gnt, 4'b0000);
    tick();
    check("fair_second", gnt, 4'b0010);
    req = '0;
    tick(3);

    // Round-robin with all requests held from reset
    #2 rst = 1'b1;
    set_ops(0, 8'h10, 8'h10);
    set_ops(1, 8'h20, 8'h01);
    set_ops(2, 8'h30, 8'h50);
    set_ops(3, 8'h40, 8'h40);
    req = 4'b1111;
    tick();
    #2 rst = 1'b0;
    rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_gnt", gnt, rr_gnt[k]);
      tick();
      check("rr_valid", rsp_valid, 1'b1);
      check("rr_id", rsp_id, exp_q.pop_front());
      if (k == 4) req = '0;
    end
    tick(3);

    // Reset during CMP: capture discarded, priority restarts at id 0
    set_ops(1, 8'h11, 8'h22);
    req = 4'b0001;
    tick();
    check("rcmp_gnt", gnt, 4'b0001);
    #2 rst = 1'b1;
    req = 4'b1111;
    tick();
    check("rcmp_valid", rsp_valid, 1'b0);
    check("rcmp_outs", {gnt, busy, rsp_id, rsp_greater, rsp_equal, rsp_less}, 10'd0);
    tick();
    check("rcmp_valid2", rsp_valid, 1'b0);
    #2 rst = 1'b0;
    tick();
    check("rcmp_first", gnt, 4'b0001);
    req = '0;
    tick(3);

    // Idle hold: last response values persist
    do_single("last", 3, 8'h10, 8'h20, 3'b001);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("hold_busy", busy, 1'b0);
      check("hold_gnt", gnt, 4'b0000);
      check("hold_valid", rsp_valid, 1'b0);
      check("hold_id", rsp_id, 2'd3);
      check("hold_flags", {rsp_greater, rsp_equal, rsp_less}, 3'b001);
      check("hold_state", dbg_state, IDLE);
    end

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
